// File: rtl/int_pkg.sv
// Shared types and constants for the nested interrupt controller.
// Stack depth depends on INT_NEST_EN: 3 when it is defined, 1 otherwise.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } int_state_e;

  localparam int LVL_W = 2;

  typedef struct packed {
    logic [31:0]      epc;
    logic [LVL_W-1:0] level;
  } stk_entry_t;

  localparam logic [31:0] ISR1_ADDR_DEF = 32'h0000_0100;
  localparam logic [31:0] ISR2_ADDR_DEF = 32'h0000_0200;
  localparam logic [31:0] ISR3_ADDR_DEF = 32'h0000_0300;

`ifdef INT_NEST_EN
  localparam int STACK_DEPTH = 3;
`else
  localparam int STACK_DEPTH = 1;
`endif

  // Level 1..3 maps to the in-service marker of source 1..3; level 0 is user code.
  function automatic logic [2:0] level_onehot(input logic [LVL_W-1:0] lvl);
    case (lvl)
      2'd1:    level_onehot = 3'b001;
      2'd2:    level_onehot = 3'b010;
      2'd3:    level_onehot = 3'b100;
      default: level_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/int_level_stack.sv
// EPC/level stack for the interrupt controller. Depth comes from the package
// (INT_NEST_EN selects 3, otherwise 1). Push on full / pop on empty are ignored;
// the controller never requests either since levels strictly increase.
module int_level_stack
  import int_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  stk_entry_t push_data,
  output stk_entry_t top,
  output logic       empty
);

  stk_entry_t mem_q [STACK_DEPTH];
  stk_entry_t mem_d [STACK_DEPTH];
  logic [1:0] cnt_q, cnt_d;

  // Next entry contents and fill count.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < STACK_DEPTH; i++) mem_d[i] = mem_q[i];
    if (push && (cnt_q < 2'(STACK_DEPTH))) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (cnt_q == 2'(i)) mem_d[i] = push_data;
      end
      cnt_d = cnt_q + 2'd1;
    end else if (pop && (cnt_q != 2'd0)) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Top-of-stack view: the most recently pushed entry.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (cnt_q == 2'(i + 1)) top = mem_q[i];
    end
  end

  assign empty = (cnt_q == 2'd0);

  // Stack storage and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/nested_int_ctrl.sv
// Priority-based nestable interrupt controller for the 5-stage pipeline.
// INT_NEST_EN defined: higher-priority sources preempt a running ISR.
// INT_NEST_EN undefined: a source is accepted only from user code (level 0).
// Handshake: resume_valid qualifies resume_pc; an interrupt is taken only in a
// cycle where resume_valid=1, and a waiting candidate is never dropped while it is 0.
module nested_int_ctrl
  import int_pkg::*;
#(
  parameter logic [31:0] ISR1_ADDR  = ISR1_ADDR_DEF,
  parameter logic [31:0] ISR2_ADDR  = ISR2_ADDR_DEF,
  parameter logic [31:0] ISR3_ADDR  = ISR3_ADDR_DEF,
  parameter int          SETTLE_CYC = 3
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [2:0]  break_i,
  input  logic [31:0] resume_pc,
  input  logic        resume_valid,
  input  logic        eret,
  output logic        int_req,
  output logic [31:0] isr_entry,
  output logic        ret_valid,
  output logic [31:0] epc_o,
  output logic [2:0]  iw,
  output logic [2:0]  ir_sig,
  output logic        busy
);

  int_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  brk_q, iw_q, iw_d, ir_q, ir_d;
  logic [1:0]  cur_level_q, cur_level_d;
  logic        int_req_q, int_req_d, ret_valid_q, ret_valid_d;
  logic        eret_pend_q, eret_pend_d;
  logic [31:0] isr_q, isr_d, epc_q, epc_d;

  logic [2:0]  rise, clr;
  logic        arb_ok, cand_valid, do_eret, push, pop, empty;
  logic [1:0]  cand_lvl;
  stk_entry_t  push_data, top;

  int_level_stack u_stack (
    .clk       (clk),
    .rst       (RST),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .top       (top),
    .empty     (empty)
  );

  assign rise      = break_i & ~brk_q;
  assign push_data = '{epc: resume_pc, level: cur_level_q};

`ifdef INT_NEST_EN
  assign arb_ok = 1'b1;
`else
  assign arb_ok = (cur_level_q == 2'd0);
`endif

  // Candidate: highest pending source whose level exceeds the current level.
  always_comb begin
    cand_valid = 1'b0;
    cand_lvl   = 2'd0;
    if (arb_ok) begin
      if (iw_q[2] && (cur_level_q < 2'd3)) begin
        cand_valid = 1'b1;
        cand_lvl   = 2'd3;
      end else if (iw_q[1] && (cur_level_q < 2'd2)) begin
        cand_valid = 1'b1;
        cand_lvl   = 2'd2;
      end else if (iw_q[0] && (cur_level_q == 2'd0)) begin
        cand_valid = 1'b1;
        cand_lvl   = 2'd1;
      end
    end
  end

  // FSM next state, issue/return bookkeeping and pending-flag update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_level_d = cur_level_q;
    ir_d        = ir_q;
    isr_d       = isr_q;
    epc_d       = epc_q;
    eret_pend_d = eret_pend_q;
    int_req_d   = 1'b0;
    ret_valid_d = 1'b0;
    clr         = 3'b000;
    do_eret     = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (eret) begin
          do_eret = 1'b1;
        end else if (cand_valid && resume_valid) begin
          push        = 1'b1;
          state_d     = ISSUE;
          cur_level_d = cand_lvl;
          clr         = level_onehot(cand_lvl);
          ir_d        = level_onehot(cand_lvl);
          int_req_d   = 1'b1;
          case (cand_lvl)
            2'd3:    isr_d = ISR3_ADDR;
            2'd2:    isr_d = ISR2_ADDR;
            default: isr_d = ISR1_ADDR;
          endcase
        end
      end
      ISSUE: begin
        state_d = SETTLE;
        cnt_d   = 3'(SETTLE_CYC - 1);
        if (eret) eret_pend_d = 1'b1;
      end
      SETTLE: begin
        do_eret     = eret | eret_pend_q;
        eret_pend_d = 1'b0;
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase

    if (do_eret && !empty) begin
      pop         = 1'b1;
      epc_d       = top.epc;
      ret_valid_d = 1'b1;
      cur_level_d = top.level;
      ir_d        = level_onehot(top.level);
    end

    iw_d = (iw_q & ~clr) | rise;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      brk_q       <= 3'b000;
      iw_q        <= 3'b000;
      ir_q        <= 3'b000;
      cur_level_q <= 2'd0;
      int_req_q   <= 1'b0;
      ret_valid_q <= 1'b0;
      eret_pend_q <= 1'b0;
      isr_q       <= 32'h0;
      epc_q       <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      brk_q       <= break_i;
      iw_q        <= iw_d;
      ir_q        <= ir_d;
      cur_level_q <= cur_level_d;
      int_req_q   <= int_req_d;
      ret_valid_q <= ret_valid_d;
      eret_pend_q <= eret_pend_d;
      isr_q       <= isr_d;
      epc_q       <= epc_d;
    end
  end

  assign int_req   = int_req_q;
  assign isr_entry = isr_q;
  assign ret_valid = ret_valid_q;
  assign epc_o     = epc_q;
  assign iw        = iw_q;
  assign ir_sig    = ir_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_nested_int_ctrl.sv
// Testbench for nested_int_ctrl: vector table, directed sequences and random
// traffic against a cycle-level reference model. Honours INT_NEST_EN.
module tb_nested_int_ctrl;

  localparam int SETTLE = 3;
`ifdef INT_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        RST;
  logic [2:0]  break_i;
  logic [31:0] resume_pc;
  logic        resume_valid, eret;
  logic        int_req, ret_valid, busy;
  logic [31:0] isr_entry, epc_o;
  logic [2:0]  iw, ir_sig;

  always #5 clk = ~clk;

  nested_int_ctrl dut (
    .clk          (clk),
    .RST          (RST),
    .break_i      (break_i),
    .resume_pc    (resume_pc),
    .resume_valid (resume_valid),
    .eret         (eret),
    .int_req      (int_req),
    .isr_entry    (isr_entry),
    .ret_valid    (ret_valid),
    .epc_o        (epc_o),
    .iw           (iw),
    .ir_sig       (ir_sig),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
    chk32(name, {29'd0, act}, {29'd0, exp});
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk32(name, {31'd0, act}, {31'd0, exp});
  endtask

  // ---------------- reference model ----------------
  // Return stack as a queue of {epc, level}; blackout counts remaining busy cycles.
  logic [33:0] exp_q[$];
  logic [2:0]  m_brk, m_iw, m_ir;
  int          m_level, m_blk;
  bit          m_defer;
  logic        m_int_req, m_ret;
  logic [31:0] m_isr, m_epc;

  task automatic model_reset();
    m_brk = 3'b0; m_iw = 3'b0; m_ir = 3'b0;
    m_level = 0; m_blk = 0; m_defer = 1'b0;
    m_int_req = 1'b0; m_ret = 1'b0; m_isr = 32'h0; m_epc = 32'h0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [2:0] b, input logic [31:0] pc,
                            input logic rv, input logic er);
    logic [2:0]  rise, clr;
    logic        take;
    int          cand;
    logic [33:0] e;
    rise = b & ~m_brk;
    m_brk = b;
    clr = 3'b0;
    take = 1'b0;
    m_int_req = 1'b0;
    m_ret = 1'b0;
    if (m_blk == 0) take = er;
    else if (m_blk == SETTLE + 1) begin
      if (er) m_defer = 1'b1;
    end else begin
      take = er | m_defer;
      m_defer = 1'b0;
    end
    cand = 0;
    if (m_blk == 0 && !er && rv) begin
      for (int k = 0; k < 3; k++)
        if (m_iw[k] && (k + 1 > m_level) && (NEST || m_level == 0)) cand = k + 1;
    end
    if (cand != 0) begin
      exp_q.push_back({pc, 2'(m_level)});
      m_level = cand;
      clr = 3'(1 << (cand - 1));
      m_ir = clr;
      m_int_req = 1'b1;
      m_isr = 32'(cand * 256);
      m_blk = SETTLE + 1;
    end else if (m_blk > 0) begin
      m_blk--;
    end
    if (take && exp_q.size() > 0) begin
      e = exp_q.pop_back();
      m_epc = e[33:2];
      m_level = int'(e[1:0]);
      m_ir = (m_level == 0) ? 3'b000 : 3'(1 << (m_level - 1));
      m_ret = 1'b1;
    end
    m_iw = (m_iw & ~clr) | rise;
  endtask

  task automatic compare_all();
    chk1("int_req", int_req, m_int_req);
    if (m_int_req) chk32("isr_entry", isr_entry, m_isr);
    chk1("ret_valid", ret_valid, m_ret);
    chk32("epc_o", epc_o, m_epc);
    chk3("iw", iw, m_iw);
    chk3("ir_sig", ir_sig, m_ir);
    chk1("busy", busy, (m_blk != 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [2:0] b, input logic [31:0] pc,
                       input logic rv, input logic er);
    break_i = b; resume_pc = pc; resume_valid = rv; eret = er;
    @(posedge clk);
    model_step(b, pc, rv, er);
    #1;
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_int_req"}, int_req, 1'b0);
    chk1({tag, "_ret_valid"}, ret_valid, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk32({tag, "_isr_entry"}, isr_entry, 32'h0);
    chk32({tag, "_epc_o"}, epc_o, 32'h0);
    chk3({tag, "_iw"}, iw, 3'b000);
    chk3({tag, "_ir_sig"}, ir_sig, 3'b000);
  endtask

  task automatic do_reset();
    RST = 1'b1; break_i = 3'b0; resume_pc = 32'h0; resume_valid = 1'b0; eret = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;
    check_all_zero("reset");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  b;
    logic [31:0] pc;
    logic        rv, er;
    logic        x_int_req;
    logic [31:0] x_isr;
    logic        x_ret;
    logic [31:0] x_epc;
    logic [2:0]  x_iw, x_ir;
    logic        x_busy;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [2:0]  b;
    logic [31:0] pc;

    // single request then return
    tbl[0] = '{3'b001, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  3'b001, 3'b000, 1'b0};
    tbl[1] = '{3'b001, 32'h40, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0,  3'b000, 3'b001, 1'b1};
    tbl[2] = '{3'b001, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  3'b000, 3'b001, 1'b1};
    tbl[3] = '{3'b001, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  3'b000, 3'b001, 1'b1};
    tbl[4] = '{3'b001, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  3'b000, 3'b001, 1'b1};
    tbl[5] = '{3'b001, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  3'b000, 3'b001, 1'b0};
    tbl[6] = '{3'b000, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h40, 3'b000, 3'b000, 1'b0};
    tbl[7] = '{3'b000, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h40, 3'b000, 3'b000, 1'b0};

    do_reset();

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].b, tbl[i].pc, tbl[i].rv, tbl[i].er);
      chk1("tbl_int_req", int_req, tbl[i].x_int_req);
      if (tbl[i].x_int_req) chk32("tbl_isr_entry", isr_entry, tbl[i].x_isr);
      chk1("tbl_ret_valid", ret_valid, tbl[i].x_ret);
      chk32("tbl_epc_o", epc_o, tbl[i].x_epc);
      chk3("tbl_iw", iw, tbl[i].x_iw);
      chk3("tbl_ir_sig", ir_sig, tbl[i].x_ir);
      chk1("tbl_busy", busy, tbl[i].x_busy);
    end

    // priority: simultaneous edges on sources 1 and 2
    drive(3'b011, 32'h80, 1'b1, 1'b0);
    chk3("prio_iw_both", iw, 3'b011);
    drive(3'b011, 32'h80, 1'b1, 1'b0);
    chk1("prio_int_req", int_req, 1'b1);
    chk32("prio_isr2", isr_entry, 32'h200);
    chk3("prio_ir2", ir_sig, 3'b010);
    chk3("prio_iw_left", iw, 3'b001);
    repeat (4) drive(3'b011, 32'h80, 1'b1, 1'b0);
    chk1("prio_no_lower", int_req, 1'b0);
    chk3("prio_iw_kept", iw, 3'b001);
    drive(3'b011, 32'h80, 1'b1, 1'b1);
    chk1("prio_ret", ret_valid, 1'b1);
    chk32("prio_epc", epc_o, 32'h80);
    chk3("prio_ir_user", ir_sig, 3'b000);
    drive(3'b011, 32'h80, 1'b1, 1'b0);
    chk1("prio_src1_req", int_req, 1'b1);
    chk32("prio_isr1", isr_entry, 32'h100);
    chk3("prio_iw_clear", iw, 3'b000);
    repeat (4) drive(3'b000, 32'h0, 1'b1, 1'b0);
    drive(3'b000, 32'h0, 1'b1, 1'b1);
    chk32("prio_epc2", epc_o, 32'h80);

    // nesting (or blocking without INT_NEST_EN) under a source-1 ISR
    drive(3'b001, 32'h40, 1'b1, 1'b0);
    drive(3'b001, 32'h40, 1'b1, 1'b0);
    chk32("nest_isr1", isr_entry, 32'h100);
    repeat (4) drive(3'b001, 32'h40, 1'b1, 1'b0);
    drive(3'b101, 32'h108, 1'b1, 1'b0);
    chk3("nest_iw3", iw, 3'b100);
`ifdef INT_NEST_EN
    drive(3'b101, 32'h108, 1'b1, 1'b0);
    chk1("nest_int_req", int_req, 1'b1);
    chk32("nest_isr3", isr_entry, 32'h300);
    chk3("nest_ir3", ir_sig, 3'b100);
    repeat (4) drive(3'b101, 32'h108, 1'b1, 1'b0);
    drive(3'b000, 32'h0, 1'b1, 1'b1);
    chk32("nest_epc1", epc_o, 32'h108);
    chk3("nest_ir1", ir_sig, 3'b001);
    drive(3'b000, 32'h0, 1'b1, 1'b0);
    chk1("nest_ret_pulse", ret_valid, 1'b0);
    drive(3'b000, 32'h0, 1'b1, 1'b1);
    chk32("nest_epc0", epc_o, 32'h40);
    chk3("nest_ir0", ir_sig, 3'b000);
`else
    repeat (2) begin
      drive(3'b101, 32'h108, 1'b1, 1'b0);
      chk1("flat_no_req", int_req, 1'b0);
      chk3("flat_iw_wait", iw, 3'b100);
    end
    drive(3'b000, 32'h108, 1'b1, 1'b1);
    chk32("flat_epc", epc_o, 32'h40);
    chk3("flat_ir0", ir_sig, 3'b000);
    drive(3'b000, 32'h108, 1'b1, 1'b0);
    chk1("flat_int_req", int_req, 1'b1);
    chk32("flat_isr3", isr_entry, 32'h300);
    chk3("flat_ir3", ir_sig, 3'b100);
    repeat (4) drive(3'b000, 32'h0, 1'b1, 1'b0);
    drive(3'b000, 32'h0, 1'b1, 1'b1);
    chk32("flat_epc2", epc_o, 32'h108);
`endif

    // blocking under source 3, resume_valid stall, eret on empty stack
    drive(3'b100, 32'h50, 1'b1, 1'b0);
    drive(3'b100, 32'h50, 1'b1, 1'b0);
    chk32("blk_isr3", isr_entry, 32'h300);
    repeat (4) drive(3'b100, 32'h50, 1'b1, 1'b0);
    drive(3'b101, 32'h50, 1'b1, 1'b0);
    chk3("blk_iw1", iw, 3'b001);
    repeat (3) begin
      drive(3'b101, 32'h50, 1'b1, 1'b0);
      chk1("blk_no_req", int_req, 1'b0);
      chk3("blk_iw_held", iw, 3'b001);
    end
    drive(3'b101, 32'h60, 1'b0, 1'b1);
    chk1("blk_ret", ret_valid, 1'b1);
    chk32("blk_epc", epc_o, 32'h50);
    repeat (5) begin
      drive(3'b101, 32'h60, 1'b0, 1'b0);
      chk1("stall_no_req", int_req, 1'b0);
      chk3("stall_iw", iw, 3'b001);
    end
    drive(3'b101, 32'h60, 1'b1, 1'b0);
    chk1("stall_req", int_req, 1'b1);
    chk32("stall_isr1", isr_entry, 32'h100);
    repeat (4) drive(3'b000, 32'h0, 1'b1, 1'b0);
    drive(3'b000, 32'h0, 1'b1, 1'b1);
    chk32("stall_epc", epc_o, 32'h60);
    drive(3'b000, 32'h0, 1'b1, 1'b1);
    chk1("empty_eret_no_ret", ret_valid, 1'b0);
    chk32("empty_eret_epc", epc_o, 32'h60);

    // asynchronous reset in the middle of SETTLE with a request pending
    drive(3'b011, 32'h70, 1'b1, 1'b0);
    drive(3'b011, 32'h70, 1'b1, 1'b0);
    drive(3'b011, 32'h70, 1'b1, 1'b0);
    chk1("pre_rst_busy", busy, 1'b1);
    chk3("pre_rst_iw", iw, 3'b001);
    #3;
    RST = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    break_i = 3'b000;
    @(posedge clk);
    #1;
    RST = 1'b0;
    drive(3'b000, 32'h0, 1'b1, 1'b0);
    chk3("post_rst_iw", iw, 3'b000);

    // random traffic against the model
    b = 3'b000;
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 3) == 0) b[k] = ~b[k];
      pc = 32'($urandom_range(0, 1023)) << 2;
      drive(b, pc, ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
